// File: rtl/uart_byte_rx.sv
// ---------------------------------------------------------------------------
// uart_byte_rx
//
// Purpose:
//   UART receiver for 8N1 frames (8E1 when UART_RX_PARITY_EN is defined).
//   The asynchronous pin is synchronised first. A falling edge is detected
//   and qualified at mid start bit. Each following bit is sampled at its
//   middle. One byte is delivered per frame together with a single-cycle
//   strobe. Framing and parity errors are reported as single-cycle strobes.
//
// Configuration macro:
//   UART_RX_PARITY_EN  - when defined, an even-parity bit is expected
//                        between D7 and the stop bit. A mismatch raises
//                        parity_err. When undefined, frames are 8N1 and
//                        parity_err is tied low.
//
// Parameters:
//   SYNC_STAGES  number of synchroniser flops on uart_rx (minimum 2)
//   DIV_W        width of the bit-period divider and the divisor register
//
// Ports:
//   clk         in   system clock (50 MHz)
//   reset       in   asynchronous, active-high reset
//   baud_set    in   0:9600 1:19200 2:38400 3:57600 4:115200, 5-7:9600
//   uart_rx     in   serial input pin, idle high, asynchronous to clk
//   data_byte   out  last byte received without error, LSB received first
//   rx_done     out  1-clk pulse, data_byte updates on the same edge
//   frame_err   out  1-clk pulse, stop bit sampled low
//   parity_err  out  1-clk pulse, parity mismatch (parity build only)
//   uart_state  out  high while a frame is in progress (START..STOP)
// ---------------------------------------------------------------------------
module uart_byte_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int DIV_W       = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] baud_set,
   input  logic       uart_rx,
   output logic [7:0] data_byte,
   output logic       rx_done,
   output logic       frame_err,
   output logic       parity_err,
   output logic       uart_state
);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd4
   } state_t;
`endif

   // ------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------
   state_t                 r_state;
   state_t                 w_state_next;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_rx_s;
   logic                   r_rx_d;
   logic                   w_start_edge;
   logic                   r_break;

   logic [DIV_W-1:0]       w_div_sel;
   logic [DIV_W-1:0]       r_div;
   logic [DIV_W-1:0]       w_half;
   logic [DIV_W-1:0]       r_div_cnt;
   logic                   w_half_hit;
   logic                   w_bit_hit;

   logic [2:0]             r_bit_cnt;
   logic [7:0]             r_shift;

   logic [7:0]             r_data_byte;
   logic                   r_rx_done;
   logic                   r_frame_err;

`ifdef UART_RX_PARITY_EN
   logic                   r_par_bit;
   logic                   r_parity_err;
   logic                   w_par_bad;
`endif

   // ------------------------------------------------------------------
   // Input synchroniser and edge detector.
   // The flops reset to 1 so that reset release never looks like a start
   // edge on an idle line.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync <= '1;
         r_rx_d <= 1'b1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], uart_rx};
         r_rx_d <= w_rx_s;
      end
   end

   assign w_rx_s = r_sync[SYNC_STAGES-1];

   // r_break blocks retriggering after a framing error until the line has
   // been seen high. Otherwise a break or a stuck-low line could chain
   // bogus frames.
   assign w_start_edge = (r_state == S_IDLE) & r_rx_d & ~w_rx_s & ~r_break;

   // ------------------------------------------------------------------
   // Baud divisor selection: one bit period is divisor+1 clocks.
   // ------------------------------------------------------------------
   always_comb begin
      w_div_sel = DIV_W'(5207);
      case (baud_set)
         3'd0:    w_div_sel = DIV_W'(5207);
         3'd1:    w_div_sel = DIV_W'(2603);
         3'd2:    w_div_sel = DIV_W'(1301);
         3'd3:    w_div_sel = DIV_W'(867);
         3'd4:    w_div_sel = DIV_W'(433);
         default: w_div_sel = DIV_W'(5207);
      endcase
   end

   assign w_half     = r_div >> 1;
   assign w_half_hit = (r_div_cnt == w_half);
   assign w_bit_hit  = (r_div_cnt == r_div);

`ifdef UART_RX_PARITY_EN
   // Even parity: the XOR of the data bits and the parity bit must be 0.
   assign w_par_bad = (^r_shift) ^ r_par_bit;
`endif

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start_edge) begin
               w_state_next = S_START;
            end
         end
         S_START: begin
            // Mid start bit: a high line means the edge was a glitch.
            if (w_half_hit) begin
               w_state_next = w_rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (w_bit_hit && (r_bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
               w_state_next = S_PARITY;
`else
               w_state_next = S_STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (w_bit_hit) begin
               w_state_next = S_STOP;
            end
         end
`endif
         S_STOP: begin
            // Leave at mid stop bit so an immediately following start edge
            // of a back-to-back frame is not missed.
            if (w_bit_hit) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath: divider counter, shift register and result strobes
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div        <= DIV_W'(5207);
         r_div_cnt    <= '0;
         r_bit_cnt    <= 3'd0;
         r_shift      <= 8'h00;
         r_data_byte  <= 8'h00;
         r_rx_done    <= 1'b0;
         r_frame_err  <= 1'b0;
         r_break      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bit    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_rx_done    <= 1'b0;
         r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err <= 1'b0;
`endif
         if (w_rx_s) begin
            r_break <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               r_div_cnt <= '0;
               r_bit_cnt <= 3'd0;
               // Latch the divisor once per frame; later baud_set changes
               // do not affect a frame in progress.
               if (w_start_edge) begin
                  r_div <= w_div_sel;
               end
            end
            S_START: begin
               if (w_half_hit) begin
                  r_div_cnt <= '0;
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (w_bit_hit) begin
                  r_div_cnt <= '0;
                  r_shift   <= {w_rx_s, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (w_bit_hit) begin
                  r_div_cnt <= '0;
                  r_par_bit <= w_rx_s;
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (w_bit_hit) begin
                  r_div_cnt <= '0;
                  // A low stop bit outranks a parity mismatch.
                  if (!w_rx_s) begin
                     r_frame_err <= 1'b1;
                     r_break     <= 1'b1;
`ifdef UART_RX_PARITY_EN
                  end else if (w_par_bad) begin
                     r_parity_err <= 1'b1;
`endif
                  end else begin
                     r_data_byte <= r_shift;
                     r_rx_done   <= 1'b1;
                  end
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end
            default: begin
               r_div_cnt <= '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign data_byte  = r_data_byte;
   assign rx_done    = r_rx_done;
   assign frame_err  = r_frame_err;
   assign uart_state = (r_state != S_IDLE);

`ifdef UART_RX_PARITY_EN
   assign parity_err = r_parity_err;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_byte_rx
//   Directed bench for uart_byte_rx. The bench sends frames bit by bit. For
//   each frame it predicts the outcome and the completion cycle from the
//   frame contents and the baud divisor. The outcome is done, frame error or
//   parity error. A negedge compare process checks every result strobe
//   against that queue and checks data_byte on every cycle. Literal checks
//   after each scenario pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_byte_rx;

   localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic       clk      = 1'b0;
   logic       reset    = 1'b0;
   logic [2:0] baud_set = 3'd4;
   logic       uart_rx  = 1'b1;
   logic [7:0] data_byte;
   logic       rx_done;
   logic       frame_err;
   logic       parity_err;
   logic       uart_state;

   uart_byte_rx #(.SYNC_STAGES(SYNC), .DIV_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .baud_set  (baud_set),
      .uart_rx   (uart_rx),
      .data_byte (data_byte),
      .rx_done   (rx_done),
      .frame_err (frame_err),
      .parity_err(parity_err),
      .uart_state(uart_state)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   // kind: 0 = rx_done, 1 = frame_err, 2 = parity_err
   typedef struct {
      int         kind;
      logic [7:0] data;
      int         due;
   } exp_t;

   exp_t       expq[$];
   logic [7:0] done_log[$];
   logic [7:0] m_last = 8'h00;
   bit         run = 1'b0;
   int         n_done = 0;
   int         n_ferr = 0;
   int         n_perr = 0;
   int         last_done_cyc = 0;
   int         last_fall = 0;
   int         cmp_kind;
   exp_t       cmp_e;

   function automatic int div_of(input int bs);
      case (bs)
         0:       return 5207;
         1:       return 2603;
         2:       return 1301;
         3:       return 867;
         4:       return 433;
         default: return 5207;
      endcase
   endfunction

   // Clocks from the pin being driven low to the result strobe. This covers
   // the synchroniser and edge register, half a bit to mid start, and then
   // full bit periods for the data bits, the optional parity bit and the
   // stop bit.
   function automatic int frame_lat(input int bs);
      return SYNC + 1 + (div_of(bs) >> 1) + 1 + (9 + PAR) * (div_of(bs) + 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, want, cyc);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s: got %0d want %0d..%0d (cyc %0d)", name, act, lo, hi, cyc);
      end
   endtask

   // ------------------------------------------------------------------
   // Compare process
   // ------------------------------------------------------------------
   always @(negedge clk) begin
      if (run && !reset) begin
         if (rx_done || frame_err || parity_err) begin
            cmp_kind = rx_done ? 0 : (frame_err ? 1 : 2);
            check("strobe_onehot", 32'(rx_done) + 32'(frame_err) + 32'(parity_err), 1);
            if (expq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_strobe: got done=%0b ferr=%0b perr=%0b want none (cyc %0d)",
                        rx_done, frame_err, parity_err, cyc);
            end else begin
               cmp_e = expq.pop_front();
               check("strobe_kind", cmp_kind, cmp_e.kind);
               check_range("strobe_time", cyc, cmp_e.due - 2, cmp_e.due + 2);
               if (cmp_kind == 0 && cmp_e.kind == 0) m_last = cmp_e.data;
            end
            if (cmp_kind == 0) begin
               n_done++;
               last_done_cyc = cyc;
               done_log.push_back(data_byte);
            end
            if (cmp_kind == 1) n_ferr++;
            if (cmp_kind == 2) n_perr++;
         end
         check("data_byte", data_byte, m_last);
         if (expq.size() > 0 && cyc > expq[0].due + 2) begin
            checks++;
            failures++;
            $display("FAIL missing_strobe: got none want kind %0d by cyc %0d", expq[0].kind, expq[0].due + 2);
            void'(expq.pop_front());
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers (all calls start and end just after a posedge)
   // ------------------------------------------------------------------
   task automatic hold(input logic v, input int n);
      uart_rx = v;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input int bs, input int bs_after,
                             input logic stop_v, input int par_force);
      int   p;
      logic par;
      exp_t e;
      p = div_of(bs) + 1;
      par = (par_force < 0) ? ^d : par_force[0];
      baud_set = 3'(bs);
      e.data = d;
      if (!stop_v)                         e.kind = 1;
      else if (PAR == 1 && par != ^d)      e.kind = 2;
      else                                 e.kind = 0;
      e.due = cyc + frame_lat(bs);
      last_fall = cyc;
      expq.push_back(e);
      hold(1'b0, p);
      baud_set = 3'(bs_after);
      for (int i = 0; i < 8; i++) hold(d[i], p);
      if (PAR == 1) hold(par, p);
      hold(stop_v, p);
   endtask

   // Low pulse of 100 clocks; counts the clocks uart_state stays high.
   task automatic glitch(input int bs, output int high_cnt);
      baud_set = 3'(bs);
      high_cnt = 0;
      uart_rx  = 1'b0;
      for (int i = 0; i < (div_of(bs) >> 1) + 400; i++) begin
         if (i == 100) uart_rx = 1'b1;
         @(posedge clk);
         #2;
         if (uart_state) high_cnt++;
      end
   endtask

   // ------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------
   initial begin
      int hc;
      int stuck;
      int d0;
      #3 reset = 1'b1;
      hold(1'b1, 3);
      check("rst_data_byte", data_byte, 8'h00);
      check("rst_rx_done", rx_done, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_parity_err", parity_err, 0);
      check("rst_uart_state", uart_state, 0);
      reset = 1'b0;
      hold(1'b1, 20);
      run = 1'b1;

      // T1: 8'hA5 at 115200
      send_frame(8'hA5, 4, 4, 1'b1, -1);
      hold(1'b1, 20);
      check("t1_byte", data_byte, 8'hA5);
      check("t1_done_cnt", n_done, 1);
      check("t1_ferr_cnt", n_ferr, 0);
      check_range("t1_latency", last_done_cyc - last_fall, 4124 + PAR * 434, 4128 + PAR * 434);

      // T2: back-to-back 00 then FF, no idle gap
      d0 = n_done;
      send_frame(8'h00, 3, 3, 1'b1, -1);
      send_frame(8'hFF, 3, 3, 1'b1, -1);
      hold(1'b1, 20);
      check("t2_done_cnt", n_done - d0, 2);
      check("t2_first", done_log[done_log.size() - 2], 8'h00);
      check("t2_second", done_log[done_log.size() - 1], 8'hFF);

      // T3: short glitches at several rates; START lasts HALF+1 clocks
      glitch(4, hc);
      check("t3_glitch_b4", hc, 217);
      glitch(0, hc);
      check("t3_glitch_b0", hc, 2604);
      glitch(7, hc);
      check("t3_glitch_b7", hc, 2604);
      glitch(2, hc);
      check("t3_glitch_b2", hc, 651);
      check("t3_no_done", n_done - d0, 2);

      // T4: stop bit low, then the line is held low (break)
      send_frame(8'h3C, 4, 4, 1'b0, -1);
      stuck = 0;
      for (int i = 0; i < 5000; i++) begin
         @(posedge clk);
         #2;
         if (uart_state) stuck++;
      end
      check("t4_no_restart", stuck, 0);
      hold(1'b1, 500);
      check("t4_ferr_cnt", n_ferr, 1);
      check("t4_byte_held", data_byte, 8'hFF);

      // T5: reset in the middle of D3, then a clean 8'h5A.
      // baud_set is changed after the start bit to show it is latched.
      hold(1'b0, 434);
      for (int i = 0; i < 3; i++) hold(i[0], 434);
      hold(1'b1, 217);
      reset   = 1'b1;
      uart_rx = 1'b1;
      m_last  = 8'h00;
      hold(1'b1, 2);
      check("t5_rst_byte", data_byte, 8'h00);
      check("t5_rst_state", uart_state, 0);
      check("t5_rst_done", rx_done, 0);
      check("t5_rst_ferr", frame_err, 0);
      reset = 1'b0;
      hold(1'b1, 20);
      send_frame(8'h5A, 4, 0, 1'b1, -1);
      hold(1'b1, 20);
      check("t5_byte", data_byte, 8'h5A);

`ifdef UART_RX_PARITY_EN
      // T6: 8'h07 has odd weight, so even parity requires a 1
      send_frame(8'h07, 4, 4, 1'b1, 0);
      hold(1'b1, 20);
      check("t6_perr_cnt", n_perr, 1);
      check("t6_byte_held", data_byte, 8'h5A);
      send_frame(8'h07, 4, 4, 1'b1, 1);
      hold(1'b1, 20);
      check("t6_byte", data_byte, 8'h07);
`endif

      hold(1'b1, 10);
      check("queue_empty", expq.size(), 0);
      check("perr_total", n_perr, PAR);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
